// File: rtl/fpu_f2i_pkg.sv
// rtl/fpu_f2i_pkg.sv - shared types and constants for the float32-to-int32 converter
package fpu_f2i_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam logic [31:0] SAT_S_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_S_MIN = 32'h8000_0000;
    localparam logic [31:0] SAT_U_MAX = 32'hFFFF_FFFF;

    localparam logic [7:0] EXP_BIAS = 8'd127;
    // Exponents at or above this give |value| >= 2^32: no shift, overflow instead.
    localparam logic [7:0] EXP_OVF  = 8'd159;

    // Alignment word: 32 integer bits above the binary point, 23 fraction bits below.
    localparam int W_WIDTH = 55;
    // Beyond 25 right shifts every mantissa bit is already in sticky.
    localparam logic [5:0] RSHIFT_MAX = 6'd25;

endpackage

// File: rtl/fpu_f2i_round.sv
// rtl/fpu_f2i_round.sv - rounding increment and signed/unsigned saturation of the aligned word
module fpu_f2i_round
    import fpu_f2i_pkg::*;
(
    input  logic [W_WIDTH-1:0] i_w,
    input  logic               i_sticky,
    input  logic               i_sign,
    input  logic [2:0]         i_rm,
    input  logic               i_signed,
    input  logic               i_nan,
    input  logic               i_ovf,
    output logic [31:0]        o_data,
    output logic               o_nv,
    output logic               o_nx
);

    logic        w_l;
    logic        w_r;
    logic        w_s;
    logic        w_inc;
    logic [32:0] w_mag;

    assign w_l   = i_w[23];
    assign w_r   = i_w[22];
    assign w_s   = (|i_w[21:0]) | i_sticky;
    assign w_mag = {1'b0, i_w[54:23]} + {32'b0, w_inc};

    // Rounding increment from guard/round/sticky; unknown modes truncate.
    always_comb begin
        w_inc = 1'b0;
        case (i_rm)
            RM_RNE:  w_inc = w_r & (w_s | w_l);
            RM_RDN:  w_inc = i_sign & (w_r | w_s);
            RM_RUP:  w_inc = ~i_sign & (w_r | w_s);
            RM_RMM:  w_inc = w_r;
            default: w_inc = 1'b0;
        endcase
    end

    // Saturate out-of-range magnitudes; NaN always saturates to the positive limit.
    always_comb begin
        o_data = 32'd0;
        o_nv   = 1'b0;
        if (i_nan) begin
            o_data = i_signed ? SAT_S_MAX : SAT_U_MAX;
            o_nv   = 1'b1;
        end else if (i_signed) begin
            if (!i_sign && (i_ovf || (w_mag >= 33'h0_8000_0000))) begin
                o_data = SAT_S_MAX;
                o_nv   = 1'b1;
            end else if (i_sign && (i_ovf || (w_mag > 33'h0_8000_0000))) begin
                o_data = SAT_S_MIN;
                o_nv   = 1'b1;
            end else if (i_sign) begin
                o_data = ~w_mag[31:0] + 32'd1;
            end else begin
                o_data = w_mag[31:0];
            end
        end else begin
            if (!i_sign && (i_ovf || w_mag[32])) begin
                o_data = SAT_U_MAX;
                o_nv   = 1'b1;
            end else if (i_sign && (i_ovf || (w_mag != 33'd0))) begin
                o_data = 32'd0;
                o_nv   = 1'b1;
            end else begin
                o_data = w_mag[31:0];
            end
        end
        o_nx = (w_r | w_s) & ~o_nv;
    end

endmodule

// File: rtl/fpu_f2i_seq.sv
// rtl/fpu_f2i_seq.sv - multicycle FCVT.W.S/FCVT.WU.S converter; FPU_F2I_FLAGS_EN adds flag_nv/flag_nx
module fpu_f2i_seq #(
    parameter int SHIFT_STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic        in_signed,
    input  logic [2:0]  in_rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
`ifdef FPU_F2I_FLAGS_EN
    ,
    output logic        flag_nv,
    output logic        flag_nx
`endif
);

    import fpu_f2i_pkg::*;

    localparam logic [5:0] STEP = 6'(SHIFT_STEP);

    state_t             r_state;
    logic [W_WIDTH-1:0] r_w;
    logic               r_sticky;
    logic               r_sign;
    logic               r_signed;
    logic [2:0]         r_rm;
    logic               r_nan;
    logic               r_ovf;
    logic               r_left;
    logic [5:0]         r_cnt;
    logic [31:0]        r_out_data;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic [7:0]         w_exp;
    logic [22:0]        w_frac;
    logic [7:0]         w_rdist;
    logic [W_WIDTH-1:0] w_w_init;
    logic               w_st_init;
    logic               w_ovf_init;
    logic               w_nan_init;
    logic               w_left_init;
    logic [5:0]         w_cnt_init;
    logic [5:0]         w_step;
    logic [W_WIDTH-1:0] w_out_mask;
    logic [31:0]        w_rnd_data;
    logic               w_nv;
    logic               w_nx;

    // Decode the incoming operand into aligner start value, direction and shift count.
    always_comb begin
        w_exp       = in_a[30:23];
        w_frac      = in_a[22:0];
        w_rdist     = EXP_BIAS - w_exp;
        w_w_init    = {31'b0, 1'b1, w_frac};
        w_st_init   = 1'b0;
        w_ovf_init  = 1'b0;
        w_nan_init  = 1'b0;
        w_left_init = 1'b1;
        w_cnt_init  = 6'd0;
        if (w_exp == 8'd0) begin
            w_w_init  = '0;
            w_st_init = |w_frac;
        end else if (w_exp >= EXP_OVF) begin
            w_ovf_init = 1'b1;
            w_nan_init = (w_exp == 8'hFF) && (w_frac != 23'd0);
        end else if (w_exp >= EXP_BIAS) begin
            w_cnt_init = 6'(w_exp - EXP_BIAS);
        end else begin
            w_left_init = 1'b0;
            w_cnt_init  = (w_rdist > 8'd25) ? RSHIFT_MAX : 6'(w_rdist);
        end
    end

    assign w_step     = (r_cnt > STEP) ? STEP : r_cnt;
    assign w_out_mask = ~({W_WIDTH{1'b1}} << w_step);

    fpu_f2i_round u_round (
        .i_w      (r_w),
        .i_sticky (r_sticky),
        .i_sign   (r_sign),
        .i_rm     (r_rm),
        .i_signed (r_signed),
        .i_nan    (r_nan),
        .i_ovf    (r_ovf),
        .o_data   (w_rnd_data),
        .o_nv     (w_nv),
        .o_nx     (w_nx)
    );

`ifdef FPU_F2I_FLAGS_EN
    logic r_nv;
    logic r_nx;
    assign flag_nv = r_nv;
    assign flag_nx = r_nx;
`else
    logic w_unused_flags;
    assign w_unused_flags = w_nv | w_nx;
`endif

    // Control FSM: accept, iterative align, round/saturate, hold result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_w         <= '0;
            r_sticky    <= 1'b0;
            r_sign      <= 1'b0;
            r_signed    <= 1'b0;
            r_rm        <= 3'd0;
            r_nan       <= 1'b0;
            r_ovf       <= 1'b0;
            r_left      <= 1'b0;
            r_cnt       <= 6'd0;
            r_out_data  <= 32'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef FPU_F2I_FLAGS_EN
            r_nv        <= 1'b0;
            r_nx        <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_w        <= w_w_init;
                        r_sticky   <= w_st_init;
                        r_sign     <= in_a[31];
                        r_signed   <= in_signed;
                        r_rm       <= in_rm;
                        r_nan      <= w_nan_init;
                        r_ovf      <= w_ovf_init;
                        r_left     <= w_left_init;
                        r_cnt      <= w_cnt_init;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= (w_cnt_init != 6'd0) ? SHIFT : ROUND;
                    end
                end
                SHIFT: begin
                    if (r_left) begin
                        r_w <= r_w << w_step;
                    end else begin
                        r_w      <= r_w >> w_step;
                        r_sticky <= r_sticky | (|(r_w & w_out_mask));
                    end
                    r_cnt <= r_cnt - w_step;
                    if (r_cnt == w_step) begin
                        r_state <= ROUND;
                    end
                end
                ROUND: begin
                    r_out_data  <= w_rnd_data;
`ifdef FPU_F2I_FLAGS_EN
                    r_nv        <= w_nv;
                    r_nx        <= w_nx;
`endif
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_busy;

endmodule

// File: tb/tb_fpu_f2i_seq.sv
// tb/tb_fpu_f2i_seq.sv - self-checking bench for fpu_f2i_seq
module tb_fpu_f2i_seq;

    localparam int STEP = 4;

    typedef struct {
        logic [31:0] d;
        logic        nv;
        logic        nx;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = 32'd0;
    logic        in_signed = 1'b0;
    logic [2:0]  in_rm = 3'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        busy;
`ifdef FPU_F2I_FLAGS_EN
    logic        flag_nv;
    logic        flag_nx;
    logic        last_nv;
`endif

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    exp_t        q[$];
    exp_t        cur;
    bit          seen = 0;
    logic [31:0] last_data;
    int          last_lat;

    fpu_f2i_seq #(.SHIFT_STEP(STEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_signed (in_signed),
        .in_rm     (in_rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef FPU_F2I_FLAGS_EN
        .flag_nv   (flag_nv),
        .flag_nx   (flag_nx),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    endtask

    // Reference: exact value mant*2^sh, rounded by comparing the remainder against one half.
    function automatic exp_t model(input logic [31:0] a, input logic s, input logic [2:0] rm);
        exp_t    r;
        int      e, sh, k;
        longint  mant, mag, qt, rem, half, val;
        bit      up, inexact;
        e    = int'(a[30:23]);
        mant = (e == 0) ? longint'(a[22:0]) : longint'({1'b1, a[22:0]});
        if (e == 0 || e >= 159) r.lat = 1;
        else if (e >= 127) r.lat = (e - 127 + STEP - 1) / STEP + 1;
        else begin
            k = 127 - e;
            if (k > 25) k = 25;
            r.lat = (k + STEP - 1) / STEP + 1;
        end
        r.acc = 0; r.nv = 1'b0; r.nx = 1'b0; inexact = 0; up = 0;
        if (e == 255 && a[22:0] != 0) begin
            r.d  = s ? 32'h7FFFFFFF : 32'hFFFFFFFF;
            r.nv = 1'b1;
            return r;
        end
        sh = (e == 0) ? -149 : e - 150;
        if (e == 255 || sh > 30) mag = longint'(1) << 40;
        else if (sh >= 0) mag = mant << sh;
        else begin
            k = -sh;
            if (k > 60) k = 60;
            qt   = mant >> k;
            rem  = mant - (qt << k);
            half = longint'(1) << (k - 1);
            case (rm)
                3'b000:  up = (rem > half) || (rem == half && qt[0]);
                3'b010:  up = a[31] && rem != 0;
                3'b011:  up = !a[31] && rem != 0;
                3'b100:  up = rem >= half;
                default: up = 0;
            endcase
            mag     = qt + longint'(up);
            inexact = rem != 0;
        end
        val = a[31] ? -mag : mag;
        if (s) begin
            if (val > 64'sd2147483647) begin r.d = 32'h7FFFFFFF; r.nv = 1'b1; end
            else if (val < -64'sd2147483648) begin r.d = 32'h80000000; r.nv = 1'b1; end
            else r.d = val[31:0];
        end else begin
            if (val > 64'sd4294967295) begin r.d = 32'hFFFFFFFF; r.nv = 1'b1; end
            else if (val < 0) begin r.d = 32'd0; r.nv = 1'b1; end
            else r.d = val[31:0];
        end
        r.nx = inexact && !r.nv;
        return r;
    endfunction

    // Single compare process: every cycle a result is presented it must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready_vs_busy", {31'b0, in_ready}, {31'b0, ~busy});
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", {31'b0, out_valid}, 32'd0);
                end else begin
                    cur = q[0];
                    chk("out_data", out_data, cur.d);
                    chk("in_ready_in_done", {31'b0, in_ready}, 32'd0);
`ifdef FPU_F2I_FLAGS_EN
                    chk("flag_nv", {31'b0, flag_nv}, {31'b0, cur.nv});
                    chk("flag_nx", {31'b0, flag_nx}, {31'b0, cur.nx});
`endif
                    if (!seen) begin
                        last_lat = cyc - cur.acc;
                        chk("latency", 32'(last_lat), 32'(cur.lat));
                        seen = 1;
                    end
                    if (out_ready) begin
                        last_data = out_data;
`ifdef FPU_F2I_FLAGS_EN
                        last_nv = flag_nv;
`endif
                        void'(q.pop_front());
                        seen = 0;
                    end
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic s, input logic [2:0] rm);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", {31'b0, in_ready}, 32'd1);
            return;
        end
        in_valid  = 1'b1;
        in_a      = a;
        in_signed = s;
        in_rm     = rm;
        e         = model(a, s, rm);
        e.acc     = cyc + 1;
        q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (q.size() == 0 && !out_valid) break;
            n++;
        end
        if (n >= 300) chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    task automatic run_vec(input logic [31:0] a, input logic s, input logic [2:0] rm,
                           input logic [31:0] exp_d, input logic exp_nv, input int exp_lat);
        last_data = 'x;
        last_lat  = -1;
        send(a, s, rm);
        wait_idle();
        chk($sformatf("lit_data_%h", a), last_data, exp_d);
        chk($sformatf("lit_lat_%h", a), 32'(last_lat), 32'(exp_lat));
`ifdef FPU_F2I_FLAGS_EN
        chk($sformatf("lit_nv_%h", a), {31'b0, last_nv}, {31'b0, exp_nv});
`else
        if (exp_nv === 1'bx) $display("note: unknown nv literal");
`endif
    endtask

    exp_t pin;
    int   hold_cnt;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        pin = model(32'h40490FDB, 1'b1, 3'b000);
        chk("model_pi", pin.d, 32'd3);
        chk("model_pi_nx", {31'b0, pin.nx}, 32'd1);
        pin = model(32'h4EFFFFFF, 1'b1, 3'b000);
        chk("model_big_lat", 32'(pin.lat), 32'd9);

        run_vec(32'h40490FDB, 1'b1, 3'b000, 32'h00000003, 1'b0, 2);
        run_vec(32'h3FC00000, 1'b1, 3'b000, 32'h00000002, 1'b0, 1);
        run_vec(32'h40200000, 1'b1, 3'b000, 32'h00000002, 1'b0, 2);
        run_vec(32'h40200000, 1'b1, 3'b100, 32'h00000003, 1'b0, 2);
        run_vec(32'h40200000, 1'b1, 3'b001, 32'h00000002, 1'b0, 2);
        run_vec(32'h40200000, 1'b1, 3'b011, 32'h00000003, 1'b0, 2);
        run_vec(32'h40200000, 1'b1, 3'b111, 32'h00000002, 1'b0, 2);
        run_vec(32'hCF000000, 1'b1, 3'b000, 32'h80000000, 1'b0, 9);
        run_vec(32'h4F000000, 1'b1, 3'b000, 32'h7FFFFFFF, 1'b1, 9);
        run_vec(32'h4F000000, 1'b0, 3'b000, 32'h80000000, 1'b0, 9);
        run_vec(32'h7FC00000, 1'b1, 3'b000, 32'h7FFFFFFF, 1'b1, 1);
        run_vec(32'hBF800000, 1'b0, 3'b000, 32'h00000000, 1'b1, 1);
        run_vec(32'hBE99999A, 1'b0, 3'b001, 32'h00000000, 1'b0, 2);
        run_vec(32'hBE99999A, 1'b1, 3'b010, 32'hFFFFFFFF, 1'b0, 2);
        run_vec(32'h4EFFFFFF, 1'b1, 3'b000, 32'h7FFFFF80, 1'b0, 9);
        run_vec(32'hFF800000, 1'b1, 3'b000, 32'h80000000, 1'b1, 1);
        run_vec(32'h7F800000, 1'b0, 3'b000, 32'hFFFFFFFF, 1'b1, 1);
        run_vec(32'h00000001, 1'b0, 3'b011, 32'h00000001, 1'b0, 1);
        run_vec(32'h80000000, 1'b1, 3'b000, 32'h00000000, 1'b0, 1);
        run_vec(32'hC0200000, 1'b1, 3'b100, 32'hFFFFFFFD, 1'b0, 2);
        run_vec(32'h3F000000, 1'b1, 3'b000, 32'h00000000, 1'b0, 2);
        run_vec(32'h3F000000, 1'b1, 3'b011, 32'h00000001, 1'b0, 2);
        run_vec(32'h33800000, 1'b1, 3'b011, 32'h00000001, 1'b0, 7);

        // Back-pressure: result held, extra operands ignored.
        out_ready = 1'b0;
        send(32'h3FC00000, 1'b1, 3'b000);
        hold_cnt = 0;
        while (!out_valid && hold_cnt < 50) begin
            @(negedge clk);
            hold_cnt++;
        end
        chk("hold_valid_seen", {31'b0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = (i < 4);
            in_a     = 32'h40490FDB;
            chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
            chk("hold_busy", {31'b0, busy}, 32'd1);
            chk("hold_data", out_data, 32'd2);
        end
        out_ready = 1'b1;
        wait_idle();
        hold_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) hold_cnt++;
        end
        chk("ignored_in_valid", 32'(hold_cnt), 32'd0);

        // Reset in the middle of a long shift.
        send(32'h4EFFFFFF, 1'b1, 3'b000);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_shift_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        q.delete();
        seen = 0;
        #1;
        chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mid_out_data", out_data, 32'd0);
        chk("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        run_vec(32'h40490FDB, 1'b1, 3'b000, 32'h00000003, 1'b0, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fpu_f2i_seq.md
Name: fpu_f2i_seq

Overview:
Multicycle float32-to-int32 converter implementing FCVT.W.S and FCVT.WU.S. It decodes an IEEE-754 single-precision operand into a 32-bit signed or unsigned integer using an iterative shifter, applies RISC-V rounding modes and saturation rules, and returns the result over a valid/ready handshake. It sits beside the FPU add/mul/div units on the FP execute path, writing to the integer register file.

Parameters:
SHIFT_STEP, 4, maximum bit positions the alignment shifter moves per cycle (1..8)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand valid
in_ready  out  1  converter can accept an operand (high only in IDLE)
in_a  in  32  float32 operand
in_signed  in  1  1 = FCVT.W.S (signed), 0 = FCVT.WU.S (unsigned)
in_rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 treated as RTZ
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  32  integer result
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1, out_valid=0, out_data=0, busy=0, all internal registers cleared. Reset mid-operation discards the operation silently.
- States:
  - IDLE: on in_valid & in_ready, capture sign, in_signed, in_rm and decode the operand, then go to SHIFT if shift count > 0, else ROUND.
  - SHIFT: move up to SHIFT_STEP positions per cycle and decrement the count; go to ROUND when the count reaches 0.
  - ROUND: one cycle; apply rounding and saturation, register out_data, go to DONE.
  - DONE: out_valid=1; on out_ready go to IDLE. out_data stays stable until the handshake.
- Latency: out_valid rises ceil(|u|/SHIFT_STEP)+1 cycles after the accept edge. u = exp-127, clamped for shift purposes.
- Datapath: 55-bit W, binary point between bits 22 and 23, loaded with {31'b0,1,frac}.
  - 0 <= u <= 31: left shift by u.
  - u < 0: right shift by min(-u,25). Every bit shifted out ORs into sticky.
  - exp==0 (zero/denormal): W=0, sticky=|frac, no shift.
  - exp >= 159 (u >= 32, including Inf/NaN): no shift; overflow flagged.
- Rounding: L=W[23], R=W[22], S=|W[21:0] | sticky. Increment by rm:
  - RNE: R&(S|L)
  - RTZ: 0
  - RDN: sign&(R|S)
  - RUP: ~sign&(R|S)
  - RMM: R
  - Magnitude M = W[54:23] + inc, computed 33 bits wide.
- Signed saturation:
  - NaN, or +M >= 2^31: 0x7FFFFFFF, invalid.
  - -M > 2^31 or -Inf: 0x80000000, invalid.
  - Otherwise the two's complement of ±M. -2^31 is exact with no invalid.
- Unsigned saturation:
  - NaN or M >= 2^32: 0xFFFFFFFF, invalid.
  - Negative with M != 0: 0x00000000, invalid.
  - Negative with M == 0: 0, not invalid.
  - Otherwise M.
- Inexact = (R|S) and not invalid. -0.0 gives 0 with no flags.
- in_valid while busy is ignored and not queued.

Optional Feature:
FPU_F2I_FLAGS_EN
- Defined: adds output ports flag_nv and flag_nx (invalid, inexact). They are registered in ROUND, valid alongside out_valid, and reset to 0.
- Undefined: the ports and flag logic are absent; out_data and timing are identical.

Decomposition:
- Package fpu_f2i_pkg: state enum (IDLE/SHIFT/ROUND/DONE), rounding-mode localparams, saturation constants (0x7FFFFFFF, 0x80000000, 0xFFFFFFFF), bias 127.
- One combinational sub-module, fpu_f2i_round: takes W, sticky, sign, rm, signed, nan and overflow; returns out_data plus nv/nx. The FSM and shifter stay in the top module.

Test Plan:
- 0x40490FDB (3.14159), signed, RNE -> 0x00000003, out_valid 2 cycles after accept, nx=1.
- 0x3FC00000 (1.5), RNE -> 2. 0x40200000 (2.5): RNE -> 2, RMM -> 3, RTZ -> 2, RUP -> 3; 1.5 has out_valid 1 cycle after accept.
- Saturation:
  - 0xCF000000 signed -> 0x80000000, nv=0.
  - 0x4F000000 signed -> 0x7FFFFFFF, nv=1.
  - 0x4F000000 unsigned -> 0x80000000, nv=0.
  - 0x7FC00000 signed -> 0x7FFFFFFF, nv=1.
- Negative unsigned:
  - 0xBF800000 (-1.0) -> 0, nv=1.
  - 0xBE99999A (-0.3), RTZ -> 0, nv=0, nx=1.
  - RDN on -0.3 signed -> 0xFFFFFFFF.
- 0x4EFFFFFF, SHIFT_STEP=4 -> 0x7FFFFF80, 8 SHIFT cycles, out_valid 9 cycles after accept.
- Handshake and reset:
  - out_ready held low 5 cycles: out_valid/out_data stable, in_ready=0, extra in_valid ignored.
  - rst_n pulsed low mid-SHIFT: outputs 0 immediately, in_ready=1; next operand converts correctly.
